vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing: `h_cnt`/`v_cnt` position counters, `visible` blanking flag, `hsync`/`vsync` and frame/line markers. It also produces a 320x240 frame-buffer read address. It is the source end of the raster interface consumed by `image_display`, which takes `h_cnt`, `v_cnt`, `visible` and returns `vga_r`/`vga_g`/`vga_b`. It sits between the board clock and the pixel pipeline and drives the VGA connector sync pins directly.

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: position counters, blanking, sync pulses, line/frame
// markers and a 2x-downscaled frame-buffer read address, all registered together.
module vga_timing_gen #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [16:0] fb_addr
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_BEG    = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_BEG    = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [16:0] LINE_STEP = 17'(H_VISIBLE / 2);
    localparam logic        SYNC_OFF  = SYNC_ACTIVE_LOW;

    // Pin level for a sync pulse given whether it is logically asserted.
    function automatic logic sync_level(input logic active);
        return active ^ SYNC_OFF;
    endfunction

    logic [9:0]  hp;
    logic [9:0]  vp;
    logic [16:0] line_base;
    logic [8:0]  col;

    logic        h_vis;
    logic        v_vis;
    logic        vis_d;
    logic        hs_d;
    logic        vs_d;
    logic        h_wrap;
    logic        v_wrap;
    logic [16:0] addr_d;

    // Decode of the current position; registered as a group so nothing is skewed.
    always_comb begin
        h_vis  = (hp < H_VIS_END);
        v_vis  = (vp < V_VIS_END);
        vis_d  = h_vis && v_vis;
        hs_d   = (hp >= HS_BEG) && (hp < HS_END);
        vs_d   = (vp >= VS_BEG) && (vp < VS_END);
        h_wrap = (hp == H_LAST);
        v_wrap = (vp == V_LAST);
        addr_d = vis_d ? (line_base + {8'd0, col}) : 17'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hp          <= 10'd0;
            vp          <= 10'd0;
            line_base   <= 17'd0;
            col         <= 9'd0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            visible     <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            fb_addr     <= 17'd0;
        end else if (ce) begin
            h_cnt       <= hp;
            v_cnt       <= vp;
            visible     <= vis_d;
            hsync       <= sync_level(hs_d);
            vsync       <= sync_level(vs_d);
            line_start  <= (hp == 10'd0);
            frame_start <= (hp == 10'd0) && (vp == 10'd0);
            fb_addr     <= addr_d;

            // col tracks hp>>1 and line_base tracks (vp>>1)*(H_VISIBLE/2).
            if (h_wrap) begin
                hp  <= 10'd0;
                col <= 9'd0;
                if (v_wrap) begin
                    vp        <= 10'd0;
                    line_base <= 17'd0;
                end else begin
                    vp <= vp + 10'd1;
                    if (vp[0]) begin
                        line_base <= line_base + LINE_STEP;
                    end
                end
            end else begin
                hp <= hp + 10'd1;
                if (hp[0]) begin
                    col <= col + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen: a full-size instance and a tiny
// instance (for frame wrap and active-high sync) both checked against a ce-count model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic [9:0]  h_cnt, v_cnt, h_cnt_s, v_cnt_s;
    logic        visible, hsync, vsync, line_start, frame_start;
    logic        visible_s, hsync_s, vsync_s, line_start_s, frame_start_s;
    logic [16:0] fb_addr, fb_addr_s;

    int n_pass = 0;
    int n_chk  = 0;
    int k      = 0;
    int last_k = 0;
    bit have_last = 1'b0;
    bit ce_seen   = 1'b0;

    localparam int TARGET  = 20 * 800 + 300 + 1;
    localparam int S_FRAME = 16 * 11;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .ce(ce),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
        .hsync(hsync), .vsync(vsync), .line_start(line_start),
        .frame_start(frame_start), .fb_addr(fb_addr)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE_LOW(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .ce(ce),
        .h_cnt(h_cnt_s), .v_cnt(v_cnt_s), .visible(visible_s),
        .hsync(hsync_s), .vsync(vsync_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .fb_addr(fb_addr_s)
    );

    // Expected outputs after kk pixel enables since reset.
    function automatic logic [41:0] model(input int kk, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb,
                                          input bit al);
        int ht, vt, p, h, v;
        logic vis, ha, va;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (kk == 0) return {10'd0, 10'd0, 1'b0, al, al, 1'b0, 1'b0, 17'd0};
        p   = kk - 1;
        h   = p % ht;
        v   = (p / ht) % vt;
        vis = (h < hv) && (v < vv);
        ha  = (h >= hv + hf) && (h < hv + hf + hs);
        va  = (v >= vv + vf) && (v < vv + vf + vs);
        return {10'(h), 10'(v), vis, al ? ~ha : ha, al ? ~va : va,
                (h == 0), (h == 0) && (v == 0),
                vis ? 17'((v / 2) * (hv / 2) + h / 2) : 17'd0};
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, want);
    endtask

    task automatic chk_vec(input string nm, input logic [41:0] got, input logic [41:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s (k=%0d): got %h expected %h", nm, k, got, want);
    endtask

    always @(posedge clk) begin
        if (rst) k <= 0;
        else if (ce) k <= k + 1;
        ce_seen <= ce && !rst;
    end

    always @(negedge clk) begin
        int p, q;
        chk_vec("main_model",
                {h_cnt, v_cnt, visible, hsync, vsync, line_start, frame_start, fb_addr},
                model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
        chk_vec("small_model",
                {h_cnt_s, v_cnt_s, visible_s, hsync_s, vsync_s, line_start_s, frame_start_s, fb_addr_s},
                model(k, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0));

        if (k == 0) begin
            chk("rst_h_cnt", h_cnt, 0);
            chk("rst_v_cnt", v_cnt, 0);
            chk("rst_hsync", hsync, 1);
            chk("rst_vsync", vsync, 1);
            chk("rst_frame_start", frame_start, 0);
            chk("rst_vsync_small", vsync_s, 0);
            have_last <= 1'b0;
        end else begin
            p = k - 1;
            q = p % S_FRAME;
            if (k == 1) begin
                chk("first_h_cnt", h_cnt, 0);
                chk("first_visible", visible, 1);
                chk("first_line_start", line_start, 1);
                chk("first_frame_start", frame_start, 1);
                chk("first_fb_addr", fb_addr, 0);
            end
            if (k == 2) begin
                chk("second_h_cnt", h_cnt, 1);
                chk("second_line_start", line_start, 0);
                chk("second_frame_start", frame_start, 0);
            end
            if (p == 640) begin
                chk("h640_visible", visible, 0);
                chk("h640_fb_addr", fb_addr, 0);
            end
            if (p == 655) chk("h655_hsync", hsync, 1);
            if (p == 656) chk("h656_hsync", hsync, 0);
            if (p == 751) chk("h751_hsync", hsync, 0);
            if (p == 752) chk("h752_hsync", hsync, 1);
            if (p == 800) begin
                chk("wrap_h_cnt", h_cnt, 0);
                chk("wrap_v_cnt", v_cnt, 1);
                chk("wrap_line_start", line_start, 1);
            end
            if (p == 2 * 800 + 2) chk("fb_2_2", fb_addr, 321);
            if (p == 3 * 800 + 3) chk("fb_3_3", fb_addr, 321);
            if (q == 87) begin
                chk("small_fb_7_5", fb_addr_s, 11);
                chk("small_vis_7_5", visible_s, 1);
            end
            if (q == 88) chk("small_fb_8_5", fb_addr_s, 0);
            if (q == 10) chk("small_hsync_on", hsync_s, 1);
            if (q == 13) chk("small_hsync_off", hsync_s, 0);
            if (q == 111) chk("small_vsync_v6", vsync_s, 0);
            if (q == 112) chk("small_vsync_v7", vsync_s, 1);
            if (q == 143) chk("small_vsync_v8", vsync_s, 1);
            if (q == 144) chk("small_vsync_v9", vsync_s, 0);
            if (q == 0) chk("small_frame_start", frame_start_s, 1);
            if (ce_seen && frame_start_s) begin
                if (have_last) chk("small_frame_period", k - last_k, S_FRAME);
                last_k    <= k;
                have_last <= 1'b1;
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        repeat (3300) @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            ce = (i % 4 == 0);
            @(negedge clk);
        end
        budget = 0;
        while (k != TARGET && budget < 40000) begin
            ce = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            budget++;
        end
        if (k != TARGET) begin
            chk("reach_target_k", k, TARGET);
        end else begin
            chk("pre_rst_h_cnt", h_cnt, 300);
            chk("pre_rst_v_cnt", v_cnt, 20);
            rst = 1'b1;
            ce  = 1'b1;
            @(negedge clk);
            chk("mid_rst_h_cnt", h_cnt, 0);
            chk("mid_rst_visible", visible, 0);
            rst = 1'b0;
            ce  = 1'b0;
            repeat (3) @(negedge clk);
            ce = 1'b1;
            @(negedge clk);
            chk("restart_frame_start", frame_start, 1);
            chk("restart_h_cnt", h_cnt, 0);
            repeat (50) @(negedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
